// File: rtl/block_lock_if.sv
// Bus between the gearbox/block_sync side and block_lock: gearbox buffer in, aligned blocks
// and lock status out, plus the lock FSM state for observation.
interface block_lock_if;
  // Valid-only stream, no backpressure: the producer raises gbox_valid_i for exactly one
  // cycle per complete block, and block_lock raises blk_valid_o for one cycle per block it
  // emits. Both sides must accept data on every cycle their valid is high.
  logic [192:0] gbox_buffer;
  logic [5:0]   gbox_cnt;
  logic         gbox_valid_i;
  logic [7:0]   block_offset_i;
  logic [63:0]  blk_data_o;
  logic [1:0]   blk_hdr_o;
  logic         blk_valid_o;
  logic         locked_o;
  logic [7:0]   lock_offset_o;
  logic         lock_loss_o;
  logic [1:0]   state;

  modport master (
    output gbox_buffer, gbox_cnt, gbox_valid_i, block_offset_i,
    input  blk_data_o, blk_hdr_o, blk_valid_o, locked_o, lock_offset_o, lock_loss_o, state
  );

  modport slave (
    input  gbox_buffer, gbox_cnt, gbox_valid_i, block_offset_i,
    output blk_data_o, blk_hdr_o, blk_valid_o, locked_o, lock_offset_o, lock_loss_o, state
  );
endinterface

// File: rtl/block_lock.sv
// Header-based lock qualification of the block_sync offset; once locked, emits aligned
// 66-bit blocks and drops lock when a window collects too many bad headers.
module block_lock #(
  parameter int LOCK_CNT   = 32,
  parameter int WINDOW     = 64,
  parameter int UNLOCK_BAD = 16
) (
  input logic         clk_i,
  input logic         rst_i,
  block_lock_if.slave bus
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int BW = $clog2(UNLOCK_BAD + 1);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    TRACK    = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t         state_q, state_n;
  logic [GW-1:0]  good_q, good_n;
  logic [WW-1:0]  win_q, win_n;
  logic [BW-1:0]  bad_q, bad_n;
  logic [7:0]     offset_q, offset_n;
  logic [63:0]    data_q, data_n;
  logic [1:0]     hdr_q, hdr_n;
  logic           valid_q, valid_n;
  logic           loss_q, loss_n;

  // Payload LSB sits at 63 - gbox_cnt + offset; the header sits directly above it.
  // With gbox_cnt <= 63 and offset <= 64 this stays within 0..127 and fits 8 bits.
  logic [7:0]     base;
  logic [63:0]    cur_data;
  logic [1:0]     cur_hdr;
  logic           hdr_good;
  logic [GW-1:0]  good_inc;
  logic [BW-1:0]  bad_inc;

  assign base     = 8'd63 - {2'b00, bus.gbox_cnt} + offset_q;
  assign cur_data = bus.gbox_buffer[base +: 64];
  assign cur_hdr  = bus.gbox_buffer[(base + 8'd64) +: 2];
  assign hdr_good = (cur_hdr == 2'b01) || (cur_hdr == 2'b10);
  assign good_inc = good_q + GW'(1);
  assign bad_inc  = bad_q + BW'(!hdr_good);

  always_comb begin
    state_n  = state_q;
    good_n   = good_q;
    win_n    = win_q;
    bad_n    = bad_q;
    offset_n = offset_q;
    data_n   = data_q;
    hdr_n    = hdr_q;
    valid_n  = 1'b0;
    loss_n   = 1'b0;

    if (bus.gbox_valid_i) begin
      unique case (state_q)
        UNLOCKED: begin
          if (bus.block_offset_i <= 8'd64) begin
            offset_n = bus.block_offset_i;
            good_n   = '0;
            state_n  = TRACK;
          end
        end

        TRACK: begin
          if (hdr_good) begin
            good_n = good_inc;
            if (good_inc == GW'(LOCK_CNT)) begin
              state_n = LOCKED;
              win_n   = '0;
              bad_n   = '0;
            end
          end else begin
            good_n  = '0;
            state_n = UNLOCKED;
          end
        end

        LOCKED: begin
          // Bad-header blocks are still forwarded; the decoder judges blk_hdr_o itself.
          valid_n = 1'b1;
          data_n  = cur_data;
          hdr_n   = cur_hdr;
          if (bad_inc == BW'(UNLOCK_BAD)) begin
            state_n = UNLOCKED;
            loss_n  = 1'b1;
            win_n   = '0;
            bad_n   = '0;
            good_n  = '0;
          end else if (win_q == WW'(WINDOW - 1)) begin
            win_n = '0;
            bad_n = '0;
          end else begin
            win_n = win_q + WW'(1);
            bad_n = bad_inc;
          end
        end

        default: begin
          state_n = UNLOCKED;
          good_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= UNLOCKED;
      good_q   <= '0;
      win_q    <= '0;
      bad_q    <= '0;
      offset_q <= '0;
      data_q   <= '0;
      hdr_q    <= '0;
      valid_q  <= 1'b0;
      loss_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      good_q   <= good_n;
      win_q    <= win_n;
      bad_q    <= bad_n;
      offset_q <= offset_n;
      data_q   <= data_n;
      hdr_q    <= hdr_n;
      valid_q  <= valid_n;
      loss_q   <= loss_n;
    end
  end

  assign bus.blk_data_o    = data_q;
  assign bus.blk_hdr_o     = hdr_q;
  assign bus.blk_valid_o   = valid_q;
  assign bus.locked_o      = (state_q == LOCKED);
  assign bus.lock_offset_o = offset_q;
  assign bus.lock_loss_o   = loss_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_block_lock.sv
// Directed bench for block_lock: lock acquisition, TRACK abort, loss of lock, window
// clearing and edge offsets with idle gaps, with a scoreboard on the emitted blocks.
module tb_block_lock;

  localparam logic [1:0] S_UNLOCKED = 2'd0;
  localparam logic [1:0] S_TRACK    = 2'd1;
  localparam logic [1:0] S_LOCKED   = 2'd2;

  logic clk;
  logic rst_n;
  block_lock_if bus ();

  block_lock dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int loss_seen = 0;
  logic [65:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: every emitted block must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.blk_valid_o) begin
        if (exp_q.size() == 0) check("blk_unexpected", 66'd1, 66'd0);
        else check("blk_out", {bus.blk_hdr_o, bus.blk_data_o}, exp_q.pop_front());
      end
      if (bus.lock_loss_o) loss_seen++;
    end
  end

  // ---------------- drivers ----------------
  task automatic scramble();
    for (int k = 0; k < 193; k++) bus.gbox_buffer[k] = 1'($urandom_range(0, 1));
    bus.gbox_cnt       = 6'($urandom_range(0, 63));
    bus.block_offset_i = 8'($urandom_range(0, 255));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.gbox_valid_i = 1'b0;
      scramble();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_block(input logic [5:0] cnt, input logic [7:0] off, input logic [7:0] cand,
                            input logic [1:0] hdr, input logic [63:0] data, input bit expect_out);
    logic [192:0] b;
    int h;
    for (int k = 0; k < 193; k++) b[k] = 1'($urandom_range(0, 1));
    h = 128 - int'(cnt) + int'(off);
    b[h -: 2] = hdr;
    b[h - 2 -: 64] = data;
    bus.gbox_buffer    = b;
    bus.gbox_cnt       = cnt;
    bus.block_offset_i = cand;
    bus.gbox_valid_i   = 1'b1;
    if (expect_out) exp_q.push_back({hdr, data});
    @(posedge clk);
    #1;
    bus.gbox_valid_i = 1'b0;
    scramble();
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic good_blk(input logic [5:0] cnt, input logic [7:0] off, input bit expect_out);
    send_block(cnt, off, 8'($urandom_range(0, 64)), good_hdr(), rnd64(), expect_out);
  endtask

  task automatic bad_blk(input logic [5:0] cnt, input logic [7:0] off, input bit expect_out);
    send_block(cnt, off, 8'($urandom_range(0, 64)), bad_hdr(), rnd64(), expect_out);
  endtask

  // Latch block in UNLOCKED followed by LOCK_CNT good headers, with optional idle gaps.
  task automatic acquire(input logic [5:0] cnt, input logic [7:0] off, input bit gaps, input string tag);
    send_block(cnt, off, off, 2'b00, rnd64(), 1'b0);
    check({tag, "_latch_off"}, 66'(bus.lock_offset_o), 66'(off));
    check({tag, "_latch_state"}, 66'(bus.state), 66'(S_TRACK));
    for (int i = 0; i < 32; i++) begin
      if (gaps) begin
        idle($urandom_range(1, 3));
        if (i == 10) check({tag, "_gap_state"}, 66'(bus.state), 66'(S_TRACK));
      end
      if (i == 31) check({tag, "_pre_lock"}, 66'(bus.locked_o), 66'd0);
      good_blk(cnt, off, 1'b0);
    end
    check({tag, "_locked"}, 66'(bus.locked_o), 66'd1);
    check({tag, "_lock_off"}, 66'(bus.lock_offset_o), 66'(off));
  endtask

  task automatic force_loss(input logic [5:0] cnt, input logic [7:0] off, input string tag);
    for (int i = 0; i < 15; i++) begin
      bad_blk(cnt, off, 1'b1);
      good_blk(cnt, off, 1'b1);
    end
    check({tag, "_pre_loss"}, 66'(bus.locked_o), 66'd1);
    bad_blk(cnt, off, 1'b1);
    check({tag, "_loss_pulse"}, 66'(bus.lock_loss_o), 66'd1);
    check({tag, "_unlocked"}, 66'(bus.locked_o), 66'd0);
    check({tag, "_blk_valid"}, 66'(bus.blk_valid_o), 66'd1);
    idle(1);
    check({tag, "_loss_end"}, 66'(bus.lock_loss_o), 66'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  h33;
    logic [63:0] d33;
    rst_n = 1'b0;
    bus.gbox_valid_i = 1'b0;
    scramble();

    // Reset with live inputs
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      scramble();
      bus.gbox_valid_i = 1'($urandom_range(0, 1));
    end
    check("rst_data", 66'(bus.blk_data_o), 66'd0);
    check("rst_hdr", 66'(bus.blk_hdr_o), 66'd0);
    check("rst_valid", 66'(bus.blk_valid_o), 66'd0);
    check("rst_locked", 66'(bus.locked_o), 66'd0);
    check("rst_off", 66'(bus.lock_offset_o), 66'd0);
    check("rst_loss", 66'(bus.lock_loss_o), 66'd0);
    bus.gbox_valid_i = 1'b0;
    rst_n = 1'b1;
    idle(2);
    check("rst_state", 66'(bus.state), 66'(S_UNLOCKED));

    // Clean lock at offset 5, gbox_cnt 0; next block out with latency 1
    acquire(6'd0, 8'd5, 1'b0, "clean");
    h33 = 2'b10;
    d33 = 64'h0123_4567_89ab_cdef;
    send_block(6'd0, 8'd5, 8'd40, h33, d33, 1'b1);
    check("first_blk_valid", 66'(bus.blk_valid_o), 66'd1);
    check("first_blk", {bus.blk_hdr_o, bus.blk_data_o}, {h33, d33});
    idle(1);
    check("first_blk_pulse", 66'(bus.blk_valid_o), 66'd0);

    // Loss of lock on the 16th bad header
    force_loss(6'd0, 8'd5, "loss1");
    check("loss1_count", 66'(loss_seen), 66'd1);

    // Out-of-range candidate offsets are ignored in UNLOCKED
    send_block(6'd0, 8'd5, 8'd65, 2'b01, rnd64(), 1'b0);
    check("cand65_state", 66'(bus.state), 66'(S_UNLOCKED));
    send_block(6'd0, 8'd5, 8'd200, 2'b01, rnd64(), 1'b0);
    check("cand200_state", 66'(bus.state), 66'(S_UNLOCKED));
    check("cand_off_hold", 66'(bus.lock_offset_o), 66'd5);

    // TRACK abort after 10 good headers, then relatch at 7 and full recount
    send_block(6'd10, 8'd5, 8'd5, 2'b00, rnd64(), 1'b0);
    for (int i = 0; i < 10; i++) good_blk(6'd10, 8'd5, 1'b0);
    check("abort_pre", 66'(bus.state), 66'(S_TRACK));
    send_block(6'd10, 8'd5, 8'd30, 2'b11, rnd64(), 1'b0);
    check("abort_state", 66'(bus.state), 66'(S_UNLOCKED));
    acquire(6'd10, 8'd7, 1'b0, "relatch");

    // 15 bad at the end of window 1 and 15 at the start of window 2: lock holds
    for (int i = 0; i < 49; i++) good_blk(6'd33, 8'd7, 1'b1);
    for (int i = 0; i < 15; i++) bad_blk(6'd33, 8'd7, 1'b1);
    check("win1_locked", 66'(bus.locked_o), 66'd1);
    for (int i = 0; i < 15; i++) bad_blk(6'd33, 8'd7, 1'b1);
    check("win2_locked", 66'(bus.locked_o), 66'd1);
    for (int i = 0; i < 49; i++) good_blk(6'd33, 8'd7, 1'b1);
    check("win_no_loss", 66'(loss_seen), 66'd1);
    force_loss(6'd33, 8'd7, "loss2");

    // Offset 0 with gbox_cnt 63, idle gaps everywhere
    acquire(6'd63, 8'd0, 1'b1, "off0");
    for (int i = 0; i < 4; i++) begin
      good_blk(6'd63, 8'd0, 1'b1);
      idle($urandom_range(1, 3));
    end
    check("off0_hold", 66'(bus.locked_o), 66'd1);
    force_loss(6'd63, 8'd0, "loss3");

    // Offset 64 with gbox_cnt 63
    acquire(6'd63, 8'd64, 1'b1, "off64");
    for (int i = 0; i < 4; i++) begin
      good_blk(6'd63, 8'd64, 1'b1);
      idle($urandom_range(1, 3));
    end
    bad_blk(6'd63, 8'd64, 1'b1);
    check("off64_hold", 66'(bus.locked_o), 66'd1);

    idle(3);
    check("loss_total", 66'(loss_seen), 66'd3);
    check("exp_q_empty", 66'(exp_q.size()), 66'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
